uart_loader: RTL and testbench

Boot-time program loader that sits directly downstream of the UART receiver. It consumes received bytes on the receiver's `data`/`ready` outputs, parses a framed download, assembles bytes into memory words and writes them sequentially into CPU instruction memory. It holds the CPU idle (`busy`) while loading and reports completion or failure.

---
 rtl/uart_loader.sv | 106 ++++++++++
 tb/tb_uart_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: parses framed UART downloads and writes assembled words into instruction memory.
module uart_loader #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int WORD_W = 8*WORD_BYTES;
    localparam int BI_W = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
    localparam int T_W = $clog2(TIMEOUT+1);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;
    state_t state;
    logic rdy_q;
    logic [7:0] len_hi, sum;
    logic [15:0] rem, len;
    logic [BI_W-1:0] bidx;
    logic [WORD_W-1:0] word;
    logic [WORD_W+7:0] shifted;
    logic [T_W-1:0] tcnt;
    logic acc, receiving, timeout, last_byte;
    always_comb begin
        acc = rx_ready & ~rdy_q;
        len = {len_hi, rx_data};
        shifted = {word, rx_data};
        last_byte = bidx == BI_W'(WORD_BYTES-1);
        receiving = state inside {LEN_HI, LEN_LO, DATA, CSUM};
        timeout = receiving && !acc && tcnt == T_W'(TIMEOUT-1);
    end
    // rdy_q resets high so a ready level already present at reset release is not a new byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rdy_q <= 1'b1;
            len_hi <= '0;
            sum <= '0;
            rem <= '0;
            bidx <= '0;
            word <= '0;
            tcnt <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            rdy_q <= rx_ready;
            mem_we <= 1'b0;
            if (mem_we) mem_addr <= mem_addr + 1'b1;
            tcnt <= (acc || !receiving) ? '0 : tcnt + 1'b1;
            case (state)
                IDLE: if (acc && rx_data == 8'hA5) begin
                    state <= LEN_HI;
                    busy <= 1'b1;
                    done <= 1'b0;
                    error <= 1'b0;
                    sum <= '0;
                    bidx <= '0;
                    mem_addr <= '0;
                end
                LEN_HI: if (acc) begin
                    len_hi <= rx_data;
                    state <= LEN_LO;
                end
                LEN_LO: if (acc) begin
                    rem <= len;
                    state <= 32'(len) > (32'd1 << ADDR_W) ? ERROR : len == '0 ? CSUM : DATA;
                end
                DATA: if (acc) begin
                    sum <= sum + rx_data;
                    word <= shifted[WORD_W-1:0];
                    bidx <= last_byte ? '0 : bidx + 1'b1;
                    if (last_byte) begin
                        mem_we <= 1'b1;
                        mem_wdata <= shifted[WORD_W-1:0];
                        rem <= rem - 1'b1;
                        if (rem == 16'd1) state <= CSUM;
                    end
                end
                CSUM: if (acc) state <= rx_data == sum ? DONE : ERROR;
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                ERROR: begin
                    error <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (timeout) state <= ERROR;
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: table vectors, corner sequences and random frames against a frame-level model.
module tb_uart_loader;
    localparam int TIMEOUT = 4096;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [95:0] b;
        int len;
        int nw;
        logic [15:0] w0;
        logic [15:0] w1;
        int res;
        bit tmo;
    } vec_t;
    logic clk = 0, reset = 0, rx_ready = 1, mem_we, busy, done, error;
    logic [7:0] rx_data = 8'hA5, mem_addr;
    logic [15:0] mem_wdata;
    vec_t tbl[6];
    logic [23:0] wq[$];
    logic [23:0] exp_w[$];
    int exp_res;
    bit exp_to;
    int long_cnt = 0;
    logic we_d = 0;
    int checks = 0, errors = 0;

    uart_loader #(.WORD_BYTES(2), .ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            if (we_d) long_cnt++;
        end
        we_d = mem_we;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_ready = 1;
        repeat (hold) @(negedge clk);
        rx_ready = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    // Frame-level reference: locate sync, read N, pair payload bytes into words, compare the sum.
    task automatic model(input bq_t f);
        int i = 0, n, k;
        logic [7:0] s = 0;
        exp_w.delete();
        exp_res = 2;
        exp_to = 0;
        while (i < f.size() && f[i] != 8'hA5) i++;
        if (i + 2 >= f.size()) begin exp_to = 1; return; end
        n = {f[i+1], f[i+2]};
        k = i + 3;
        if (n > 256) return;
        for (int w = 0; w < n; w++) begin
            if (k + 1 >= f.size()) begin exp_to = 1; return; end
            exp_w.push_back({8'(w), f[k], f[k+1]});
            s += f[k] + f[k+1];
            k += 2;
        end
        if (k >= f.size()) begin exp_to = 1; return; end
        exp_res = (f[k] == s) ? 1 : 2;
    endtask

    task automatic run_frame(input bq_t f, input int hold, input string nm);
        int base = wq.size();
        int lb = long_cnt;
        foreach (f[i]) send(f[i], hold);
        repeat (exp_to ? TIMEOUT + 20 : 10) @(negedge clk);
        chk({nm, " nwrites"}, wq.size() - base, exp_w.size());
        for (int i = 0; i < exp_w.size() && base + i < wq.size(); i++) begin
            chk({nm, " waddr"}, int'(wq[base+i][23:16]), int'(exp_w[i][23:16]));
            chk({nm, " wdata"}, int'(wq[base+i][15:0]), int'(exp_w[i][15:0]));
        end
        chk({nm, " done"}, done, exp_res == 1);
        chk({nm, " error"}, error, exp_res == 2);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " we_width"}, long_cnt - lb, 0);
    endtask

    initial begin
        bq_t f;
        logic [7:0] s;
        tbl[0] = '{b:96'hA5_00_02_12_34_56_78_14_00_00_00_00, len:8, nw:2, w0:16'h1234, w1:16'h5678, res:1, tmo:0};
        tbl[1] = '{b:96'hA5_00_02_12_34_56_78_15_00_00_00_00, len:8, nw:2, w0:16'h1234, w1:16'h5678, res:2, tmo:0};
        tbl[2] = '{b:96'hA5_00_00_00_00_00_00_00_00_00_00_00, len:4, nw:0, w0:0, w1:0, res:1, tmo:0};
        tbl[3] = '{b:96'hA5_01_01_00_00_00_00_00_00_00_00_00, len:3, nw:0, w0:0, w1:0, res:2, tmo:0};
        tbl[4] = '{b:96'hA5_00_00_01_00_00_00_00_00_00_00_00, len:4, nw:0, w0:0, w1:0, res:2, tmo:0};
        tbl[5] = '{b:96'hA5_00_01_12_00_00_00_00_00_00_00_00, len:4, nw:0, w0:0, w1:0, res:2, tmo:1};
        #2 reset = 1;
        #1;
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (5) @(negedge clk);
        chk("ready high at release", busy, 0);
        rx_ready = 0;
        repeat (2) @(negedge clk);
        foreach (tbl[0].b[i]) if (i < 3) begin
            send(i == 0 ? 8'h00 : i == 1 ? 8'hFF : 8'h12, 2);
            chk("idle noise busy", busy, 0);
        end
        for (int t = 0; t < 6; t++) begin
            f.delete();
            for (int i = 0; i < tbl[t].len; i++) f.push_back(tbl[t].b[95-8*i -: 8]);
            exp_w.delete();
            if (tbl[t].nw > 0) exp_w.push_back({8'd0, tbl[t].w0});
            if (tbl[t].nw > 1) exp_w.push_back({8'd1, tbl[t].w1});
            exp_res = tbl[t].res;
            exp_to = tbl[t].tmo;
            run_frame(f, 2, $sformatf("vec%0d", t));
        end
        send(8'hA5, 2);
        repeat (3) @(negedge clk);
        chk("sync clears error", error, 0);
        chk("sync clears done", done, 0);
        chk("sync sets busy", busy, 1);
        f = '{8'h00, 8'h00, 8'h00};
        exp_w.delete();
        exp_res = 1;
        exp_to = 0;
        run_frame(f, 2, "resumed empty");
        f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
        model(f);
        run_frame(f, 50, "held ready");
        f = '{8'hA5, 8'h01, 8'h00};
        s = 0;
        for (int i = 0; i < 512; i++) begin
            f.push_back(8'($urandom_range(0, 255)));
            s += f[f.size()-1];
        end
        f.push_back(s);
        model(f);
        run_frame(f, 1, "n256");
        chk("addr wrap", mem_addr, 0);
        for (int r = 0; r < 20; r++) begin
            int kind = $urandom_range(0, 9);
            int n = $urandom_range(0, 6);
            f.delete();
            repeat ($urandom_range(0, 2)) begin
                s = 8'($urandom_range(0, 255));
                f.push_back(s == 8'hA5 ? 8'h00 : s);
            end
            if (kind == 0) n = 257 + $urandom_range(0, 1000);
            f.push_back(8'hA5);
            f.push_back(8'(n >> 8));
            f.push_back(8'(n));
            if (kind != 0) begin
                s = 0;
                for (int i = 0; i < 2*n; i++) begin
                    f.push_back(8'($urandom_range(0, 255)));
                    s += f[f.size()-1];
                end
                f.push_back(kind == 1 ? s + 8'($urandom_range(1, 255)) : s);
                if (kind == 2) repeat ($urandom_range(1, 2*n + 1)) void'(f.pop_back());
            end
            model(f);
            run_frame(f, $urandom_range(1, 3), $sformatf("rand%0d", r));
        end
        f = '{8'hA5, 8'h00, 8'h02, 8'h12};
        foreach (f[i]) send(f[i], 2);
        @(negedge clk);
        rx_data = 8'h34;
        rx_ready = 1;
        @(posedge clk);
        #1;
        chk("write strobe", mem_we, 1);
        chk("write addr", mem_addr, 0);
        chk("write data", mem_wdata, 16'h1234);
        reset = 1;
        #1;
        chk("async mem_we", mem_we, 0);
        chk("async mem_addr", mem_addr, 0);
        chk("async mem_wdata", mem_wdata, 0);
        chk("async busy", busy, 0);
        chk("async done", done, 0);
        chk("async error", error, 0);
        rx_ready = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        f = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
        model(f);
        run_frame(f, 2, "after reset");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
